ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h80000000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port ifetch_req, input, 1, one-cycle pulse from the execute stage requesting the next fetch.
REQ-005 SHALL have port ifetch_taken, input, 1, qualifies ifetch_req: 1 means ifetch_pc is a redirect (branch/jump/trap).
REQ-006 SHALL have port ifetch_pc, input, 64, address to fetch; sampled only when ifetch_req=1.
REQ-007 SHALL have ports IFU_vld (output, 1), IFU_pc (output, 64) and IFU_inst (output, 64): one-cycle pulse and the fetched pc and zero-extended 32-bit instruction for the decode stage.
REQ-008 SHALL have port IFU_misalign, output, 1, one-cycle pulse flagging a fetch request with pc[1:0]!=0.
REQ-009 SHALL have ports axi_AR_ADDR (output, 64), axi_AR_VALID (output, 1) and axi_AR_READY (input, 1): the AXI read-address channel.
REQ-010 SHALL have ports axi_R_DATA (input, 64), axi_R_VALID (input, 1) and axi_R_READY (output, 1): the AXI read-data channel.

Function
REQ-011 SHALL implement FSM states BOOT, IDLE, AR, R, OUT.
REQ-012 BOOT SHALL last exactly one cycle after reset release; it loads fetch pc=RESET_PC, then goes to AR.
REQ-013 In IDLE, ifetch_req=1 with ifetch_pc[1:0]==0 SHALL latch the pc and go to AR (or OUT on a line-buffer hit, see Configuration).
REQ-014 In IDLE, ifetch_req=1 with ifetch_pc[1:0]!=0 SHALL pulse IFU_misalign next cycle, issue no AXI request and stay in IDLE.
REQ-015 axi_AR_VALID SHALL be 1 exactly while in AR; axi_AR_ADDR = {pc[63:3],3'b000}, held stable until handshake.
REQ-016 AR SHALL go to R on the cycle axi_AR_VALID & axi_AR_READY.
REQ-017 axi_R_READY SHALL be 1 exactly while in R.
REQ-018 On axi_R_VALID & axi_R_READY, the block SHALL capture the 64-bit beat and go to OUT.
REQ-019 In OUT, IFU_vld SHALL be 1 for that single cycle; the FSM then returns to IDLE.
REQ-020 IFU_inst SHALL be {32'b0, pc[2] ? beat[63:32] : beat[31:0]}.
REQ-021 IFU_pc SHALL equal the latched pc; IFU_pc and IFU_inst SHALL hold their values until the next OUT.
REQ-022 ifetch_req outside IDLE SHALL be ignored: no queueing, no state change.
REQ-023 Minimum miss latency SHALL be req at cycle t, AR_VALID at t+1, R_READY at t+2, IFU_vld at t+3 (zero-wait slave).
REQ-024 The block SHALL tolerate AR_READY high before AR_VALID and R_VALID held for many cycles, consuming exactly one beat per request.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately, independent of clk, force FSM=BOOT, axi_AR_VALID=0, axi_R_READY=0, IFU_vld=0, IFU_misalign=0, IFU_pc=RESET_PC, IFU_inst=0, axi_AR_ADDR=0, line buffer invalid.
REQ-026 Reset during AR or R SHALL abandon the transaction; no IFU_vld for it; after release a fresh BOOT fetch SHALL occur.

Configuration
REQ-027 Macro IFU_LINEBUF_EN SHALL, when defined, add a one-entry 64-bit line buffer with a tag pc[63:3] and a valid bit, filled on every R handshake.
REQ-028 With IFU_LINEBUF_EN, an IDLE request with ifetch_taken=0 and tag match SHALL go straight to OUT: IFU_vld at t+1, no AXI activity.
REQ-029 With IFU_LINEBUF_EN, ifetch_taken=1 SHALL invalidate the buffer before lookup, forcing an AXI fetch.
REQ-030 Without IFU_LINEBUF_EN, every aligned request SHALL perform an AXI fetch, and no buffer storage SHALL exist.

Verification
REQ-031 Reset release, zero-wait slave returning 64'h00100093_00000413 for addr 0x80000000 -> AR_ADDR=0x80000000, IFU_vld at cycle 4 with IFU_pc=0x80000000 and IFU_inst=0x00000413.
REQ-032 ifetch_req with pc=0x80000004, taken=0, LINEBUF enabled -> IFU_vld next cycle, IFU_inst=0x00100093, AR_VALID stays 0; with the macro undefined -> AR_ADDR=0x80000000 issued.
REQ-033 ifetch_req with pc=0x80000004, taken=1, LINEBUF enabled -> AXI fetch at 0x80000000 occurs despite a tag match.
REQ-034 AR_READY delayed 5 cycles and R_VALID delayed 7 -> AR_ADDR stable throughout, exactly one IFU_vld, a second ifetch_req during the wait is ignored.
REQ-035 ifetch_req with pc=0x80000002 -> IFU_misalign pulse, no AR_VALID, no IFU_vld.
REQ-036 rst_n dropped while in R -> R_READY falls the same cycle, no IFU_vld; after release a BOOT fetch at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch unit bundle: execute-stage request, decode-stage result,
// and the AXI read-address/read-data channels.
interface ifu_fetch_if;
  logic        ifetch_req;
  logic        ifetch_taken;
  logic [63:0] ifetch_pc;

  logic        IFU_vld;
  logic [63:0] IFU_pc;
  logic [63:0] IFU_inst;
  logic        IFU_misalign;

  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY;

  logic [63:0] axi_R_DATA;
  logic        axi_R_VALID;
  logic        axi_R_READY;

  modport master (
    input  ifetch_req,
    input  ifetch_taken,
    input  ifetch_pc,
    output IFU_vld,
    output IFU_pc,
    output IFU_inst,
    output IFU_misalign,
    output axi_AR_ADDR,
    output axi_AR_VALID,
    input  axi_AR_READY,
    input  axi_R_DATA,
    input  axi_R_VALID,
    output axi_R_READY
  );

  modport slave (
    output ifetch_req,
    output ifetch_taken,
    output ifetch_pc,
    input  IFU_vld,
    input  IFU_pc,
    input  IFU_inst,
    input  IFU_misalign,
    input  axi_AR_ADDR,
    input  axi_AR_VALID,
    output axi_AR_READY,
    output axi_R_DATA,
    output axi_R_VALID,
    input  axi_R_READY
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one 64-bit AXI beat per request.
// Define IFU_LINEBUF_EN for a one-entry line buffer bypassing AXI.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h80000000
) (
  input logic         clk,
  input logic         rst_n,
  ifu_fetch_if.master bus
);

  localparam logic [2:0] BOOT = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] AR   = 3'd2;
  localparam logic [2:0] R    = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ar_addr_q, ar_addr_d;
  logic [63:0] ipc_q, ipc_d;
  logic [63:0] inst_q, inst_d;
  logic        mis_q, mis_d;

  logic        ar_hs;
  logic        r_hs;
  logic        req_ok;
  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] r_word;

  assign bus.axi_AR_VALID = (state_q == AR);
  assign bus.axi_R_READY  = (state_q == R);
  assign bus.axi_AR_ADDR  = ar_addr_q;
  assign bus.IFU_vld      = (state_q == OUT);
  assign bus.IFU_pc       = ipc_q;
  assign bus.IFU_inst     = inst_q;
  assign bus.IFU_misalign = mis_q;

  assign ar_hs  = bus.axi_AR_VALID & bus.axi_AR_READY;
  assign r_hs   = bus.axi_R_VALID & bus.axi_R_READY;
  assign req_ok = (state_q == IDLE) & bus.ifetch_req
                & (bus.ifetch_pc[1:0] == 2'b00);
  assign r_word = pc_q[2] ? bus.axi_R_DATA[63:32]
                          : bus.axi_R_DATA[31:0];

`ifdef IFU_LINEBUF_EN
  logic        lb_vld_q;
  logic [60:0] lb_tag_q;
  logic [63:0] lb_data_q;
  logic        lb_clr;

  // A redirect drops the buffer before lookup, so it never hits
  assign lb_clr = (state_q == IDLE) & bus.ifetch_req
                & bus.ifetch_taken;
  assign hit = req_ok & ~bus.ifetch_taken & lb_vld_q
             & (lb_tag_q == bus.ifetch_pc[63:3]);
  assign hit_word = bus.ifetch_pc[2] ? lb_data_q[63:32]
                                     : lb_data_q[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_vld_q  <= 1'b0;
      lb_tag_q  <= '0;
      lb_data_q <= '0;
    end else if (r_hs) begin
      lb_vld_q  <= 1'b1;
      lb_tag_q  <= pc_q[63:3];
      lb_data_q <= bus.axi_R_DATA;
    end else if (lb_clr) begin
      lb_vld_q  <= 1'b0;
    end
  end
`else
  logic unused_taken;

  assign unused_taken = bus.ifetch_taken;
  assign hit          = 1'b0;
  assign hit_word     = 32'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ar_addr_d = ar_addr_q;
    ipc_d     = ipc_q;
    inst_d    = inst_q;
    mis_d     = 1'b0;
    unique case (1'b1)
      (state_q == BOOT): begin
        pc_d      = RESET_PC;
        ar_addr_d = {RESET_PC[63:3], 3'b000};
        state_d   = AR;
      end
      (state_q == IDLE): begin
        if (hit) begin
          pc_d    = bus.ifetch_pc;
          ipc_d   = bus.ifetch_pc;
          inst_d  = {32'b0, hit_word};
          state_d = OUT;
        end else if (req_ok) begin
          pc_d      = bus.ifetch_pc;
          ar_addr_d = {bus.ifetch_pc[63:3], 3'b000};
          state_d   = AR;
        end else if (bus.ifetch_req) begin
          mis_d = 1'b1;
        end
      end
      (state_q == AR): begin
        if (ar_hs) state_d = R;
      end
      (state_q == R): begin
        if (r_hs) begin
          ipc_d   = pc_q;
          inst_d  = {32'b0, r_word};
          state_d = OUT;
        end
      end
      (state_q == OUT): begin
        state_d = IDLE;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      ar_addr_q <= '0;
      ipc_q     <= RESET_PC;
      inst_q    <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ar_addr_q <= ar_addr_d;
      ipc_q     <= ipc_d;
      inst_q    <= inst_d;
      mis_q     <= mis_d;
    end
  end

endmodule
